// File: rtl/spi_cmd_slave.sv
// spi_cmd_slave: oversampled SPI mode-0 command slave with write FIFO and in-frame read port.
// Optional error counter enabled by defining SPI_CMD_SLAVE_ERR_COUNT_EN.
`timescale 1ns/1ps
module spi_cmd_slave #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                               sys_clk,
    input  logic                               sys_rst_n,
    input  logic                               spi_sck,
    input  logic                               spi_mosi,
    input  logic                               spi_cs_n,
    output logic                               spi_miso,
    output logic                               cmd_valid,
    input  logic                               cmd_ready,
    output logic [ADDR_W-1:0]                  cmd_addr,
    output logic [DATA_W-1:0]                  cmd_data,
    output logic                               rd_req,
    output logic [ADDR_W-1:0]                  rd_addr,
    input  logic                               rd_valid,
    input  logic [DATA_W-1:0]                  rd_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic [2:0]                         err_flags,
    input  logic                               err_clr,
    output logic [7:0]                         err_count
);
    localparam int CW = $clog2(ADDR_W + DATA_W + 1);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {SYNC, IDLE, HDR, WDATA, RDATA, DONE} state_t;

    state_t                     state;
    logic [2:0]                 sck_s;
    logic [1:0]                 mosi_s;
    logic [1:0]                 cs_s;
    logic                       rise, fall, mosi, cs;
    logic [CW-1:0]              cnt;
    logic [DATA_W-1:0]          shift;
    logic [ADDR_W:0]            hdr;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          rsp;
    logic                       have, started, push;
    logic                       abort_fire, urun_fire, ovf_fire, capture;
    logic [2:0]                 fire;
    logic [ADDR_W+DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]              wp, rp;
    logic                       full, pop, wr_en;

    assign rise    = sck_s[1] & ~sck_s[2];
    assign fall    = ~sck_s[1] & sck_s[2];
    assign mosi    = mosi_s[1];
    assign cs      = cs_s[1];
    assign hdr     = {shift[ADDR_W-1:0], mosi};
    assign capture = rd_valid & ~have & ~started & ~fall;

    assign abort_fire = cs & (state == HDR || state == WDATA || state == RDATA);
    assign urun_fire  = (state == RDATA) & ~cs & fall & ~started & ~have;
    assign ovf_fire   = push & full & ~pop;
    assign fire       = {urun_fire, ovf_fire, abort_fire};

    // Pad synchronisers; CS_N resets to "asserted" so SYNC waits for a real deassertion
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            sck_s  <= '0;
            mosi_s <= '0;
            cs_s   <= '0;
        end else begin
            sck_s  <= {sck_s[1:0], spi_sck};
            mosi_s <= {mosi_s[0], spi_mosi};
            cs_s   <= {cs_s[0], spi_cs_n};
        end

    // Frame decoder FSM with registered rd_req, push and MISO
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            state    <= SYNC;
            cnt      <= '0;
            shift    <= '0;
            wr_addr  <= '0;
            rd_addr  <= '0;
            rd_req   <= 1'b0;
            push     <= 1'b0;
            rsp      <= '0;
            have     <= 1'b0;
            started  <= 1'b0;
            spi_miso <= 1'b0;
        end else begin
            rd_req <= 1'b0;
            push   <= 1'b0;
            case (state)
                SYNC: begin
                    spi_miso <= 1'b0;
                    if (cs) state <= IDLE;
                end
                IDLE: begin
                    cnt      <= '0;
                    shift    <= '0;
                    spi_miso <= 1'b0;
                    if (!cs) state <= HDR;
                end
                HDR: begin
                    if (cs) state <= IDLE;
                    else if (rise) begin
                        shift <= {shift[DATA_W-2:0], mosi};
                        cnt   <= cnt + 1'b1;
                        if (cnt == CW'(ADDR_W)) begin
                            cnt <= '0;
                            if (hdr[ADDR_W]) begin
                                rd_req  <= 1'b1;
                                rd_addr <= hdr[ADDR_W-1:0];
                                have    <= 1'b0;
                                started <= 1'b0;
                                state   <= RDATA;
                            end else begin
                                wr_addr <= hdr[ADDR_W-1:0];
                                state   <= WDATA;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (cs) state <= IDLE;
                    else if (rise) begin
                        shift <= {shift[DATA_W-2:0], mosi};
                        cnt   <= cnt + 1'b1;
                        if (cnt == CW'(DATA_W - 1)) begin
                            push  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RDATA: begin
                    if (cs) begin
                        spi_miso <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        if (capture) begin
                            rsp  <= rd_data;
                            have <= 1'b1;
                        end
                        if (fall) begin
                            spi_miso <= have & rsp[DATA_W-1];
                            rsp      <= rsp << 1;
                            started  <= 1'b1;
                        end
                        if (rise) begin
                            cnt <= cnt + 1'b1;
                            if (cnt == CW'(DATA_W - 1)) begin
                                spi_miso <= 1'b0;
                                state    <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    spi_miso <= 1'b0;
                    if (cs) state <= IDLE;
                end
                default: state <= SYNC;
            endcase
        end

    assign full       = (wp - rp) == PW'(FIFO_DEPTH);
    assign cmd_valid  = wp != rp;
    assign pop        = cmd_valid & cmd_ready;
    assign wr_en      = push & (~full | pop);
    assign fifo_level = LW'(wp - rp);
    assign {cmd_addr, cmd_data} = mem[rp[PW-2:0]];

    // FIFO pointers
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_en) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end

    // FIFO storage; the last shifted data word is held stable during the push cycle
    always_ff @(posedge sys_clk)
        if (wr_en) mem[wp[PW-2:0]] <= {wr_addr, shift};

    // Sticky error flags; a new error in the clearing cycle survives the clear
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) err_flags <= '0;
        else err_flags <= (err_clr ? 3'b000 : err_flags) | fire;

`ifdef SPI_CMD_SLAVE_ERR_COUNT_EN
    logic [7:0] cnt_base;
    assign cnt_base = err_clr ? 8'd0 : err_count;
    // Saturating count of cycles in which any error source fires
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) err_count <= '0;
        else err_count <= (|fire && cnt_base != 8'hff) ? cnt_base + 8'd1 : cnt_base;
`else
    assign err_count = 8'd0;
`endif
endmodule

// File: tb/tb_spi_cmd_slave.sv
// tb_spi_cmd_slave: scoreboard bench for spi_cmd_slave driving SPI frames from a host model.
`timescale 1ns/1ps
module tb_spi_cmd_slave;
    localparam int H = 60;

    logic        sys_clk = 0, sys_rst_n = 0;
    logic        spi_sck = 0, spi_mosi = 0, spi_cs_n = 1, spi_miso;
    logic        cmd_valid, cmd_ready = 1;
    logic [6:0]  cmd_addr, rd_addr;
    logic [63:0] cmd_data, rd_data = 0;
    logic        rd_req, rd_valid = 0, err_clr = 0;
    logic [4:0]  fifo_level;
    logic [2:0]  err_flags;
    logic [7:0]  err_count;

    int checks = 0, failures = 0, pop_cnt = 0, rdreq_cnt = 0;
    logic [70:0] exp_cmd[$];
    logic [6:0]  exp_rdaddr[$];
    logic [63:0] exp_rd[$];
    logic        resp_en = 0;
    logic [63:0] resp_data = 0, got;

    spi_cmd_slave dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n), .spi_miso(spi_miso), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data), .fifo_level(fifo_level), .err_flags(err_flags),
        .err_clr(err_clr), .err_count(err_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write-command monitor: every accepted FIFO head is popped against the scoreboard
    always @(negedge sys_clk)
        if (sys_rst_n && cmd_valid && cmd_ready) begin
            pop_cnt++;
            if (exp_cmd.size() == 0) chk("unexpected_cmd", {cmd_addr, cmd_data}, 71'h0);
            else chk("cmd", {cmd_addr, cmd_data}, exp_cmd.pop_front());
        end

    // Read responder: checks rd_addr and optionally returns data two cycles later
    initial forever begin
        @(negedge sys_clk);
        if (sys_rst_n && rd_req) begin
            rdreq_cnt++;
            if (exp_rdaddr.size() == 0) chk("unexpected_rd_req", 71'(rd_addr), 71'h7f);
            else chk("rd_addr", 71'(rd_addr), 71'(exp_rdaddr.pop_front()));
            if (resp_en) begin
                @(posedge sys_clk);
                @(posedge sys_clk);
                #1 rd_valid = 1;
                rd_data = resp_data;
                @(posedge sys_clk);
                #1 rd_valid = 0;
            end
        end
    end

    task automatic spi_bits(input logic [71:0] f, input int lo, input int hi, inout logic [63:0] w);
        for (int i = lo; i < hi; i++) begin
            spi_mosi = f[71-i];
            #(H);
            if (i >= 8) w = {w[62:0], spi_miso};
            spi_sck = 1;
            #(H);
            spi_sck = 0;
        end
    endtask

    task automatic spi_frame(input logic [71:0] f, input int n, output logic [63:0] w);
        w = 0;
        spi_cs_n = 0;
        #(H);
        spi_bits(f, 0, n, w);
        #(H);
        spi_cs_n = 1;
        spi_mosi = 0;
        #(4*H);
    endtask

    task automatic clear_errs();
        err_clr = 1;
        @(posedge sys_clk);
        #2 err_clr = 0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_cmd.size() != 0 && n < 2000) begin
            @(posedge sys_clk);
            n++;
        end
        #2;
        chk("drain_timeout", 71'(exp_cmd.size()), 71'h0);
    endtask

    logic [71:0] fr;
    int p0, r0;
    logic [7:0] exp_cnt1;

    initial begin
`ifdef SPI_CMD_SLAVE_ERR_COUNT_EN
        exp_cnt1 = 8'd1;
`else
        exp_cnt1 = 8'd0;
`endif
        #7;
        #(30);
        chk("rst_cmd_valid", 71'(cmd_valid), 71'h0);
        chk("rst_fifo_level", 71'(fifo_level), 71'h0);
        chk("rst_err_flags", 71'(err_flags), 71'h0);
        chk("rst_miso_rdreq", 71'({spi_miso, rd_req, err_count}), 71'h0);
        sys_rst_n = 1;
        #(100);

        exp_cmd.push_back({7'h12, 64'hDEADBEEF_01234567});
        spi_frame({1'b0, 7'h12, 64'hDEADBEEF_01234567}, 72, got);
        wait_drain();
        chk("wr_level", 71'(fifo_level), 71'h0);
        chk("wr_flags", 71'(err_flags), 71'h0);

        resp_en = 1;
        resp_data = 64'hA5A5_0000_FFFF_1234;
        exp_rdaddr.push_back(7'h05);
        exp_rd.push_back(64'hA5A5_0000_FFFF_1234);
        spi_frame({1'b1, 7'h05, 64'h0}, 72, got);
        chk("rd_miso", 71'(got), 71'(exp_rd.pop_front()));
        chk("rd_addr_hold", 71'(rd_addr), 71'h05);
        chk("rd_flags", 71'(err_flags), 71'h0);

        resp_en = 0;
        clear_errs();
        exp_rdaddr.push_back(7'h33);
        exp_rd.push_back(64'h0);
        spi_frame({1'b1, 7'h33, 64'hFFFF_FFFF_FFFF_FFFF}, 72, got);
        chk("urun_miso", 71'(got), 71'(exp_rd.pop_front()));
        chk("urun_flags", 71'(err_flags), 71'b100);
        chk("urun_count", 71'(err_count), 71'(exp_cnt1));

        clear_errs();
        cmd_ready = 0;
        for (int k = 0; k < 17; k++) begin
            fr = {1'b0, 7'(k + 8'h40), 64'h1111_0000_0000_0000 + 64'(k * 64'h101)};
            if (k < 16) exp_cmd.push_back(fr[70:0]);
            spi_frame(fr, 72, got);
        end
        chk("ovf_level", 71'(fifo_level), 71'd16);
        chk("ovf_flags", 71'(err_flags), 71'b010);
        chk("ovf_count", 71'(err_count), 71'(exp_cnt1));
        clear_errs();
        cmd_ready = 1;
        wait_drain();
        chk("ovf_drained_level", 71'(fifo_level), 71'h0);

        p0 = pop_cnt;
        r0 = rdreq_cnt;
        spi_frame({1'b0, 7'h21, 64'h0123_4567_89AB_CDEF}, 40, got);
        #(200);
        chk("abort_flags", 71'(err_flags), 71'b001);
        chk("abort_no_push", 71'(pop_cnt - p0), 71'h0);
        chk("abort_no_rdreq", 71'(rdreq_cnt - r0), 71'h0);
        chk("abort_level", 71'(fifo_level), 71'h0);
        clear_errs();
        exp_cmd.push_back({7'h22, 64'hCAFE_F00D_0000_0001});
        spi_frame({1'b0, 7'h22, 64'hCAFE_F00D_0000_0001}, 72, got);
        wait_drain();
        chk("post_abort_flags", 71'(err_flags), 71'h0);

        p0 = pop_cnt;
        fr = {1'b0, 7'h55, 64'h5555_6666_7777_8888};
        got = 0;
        spi_cs_n = 0;
        #(H);
        spi_bits(fr, 0, 20, got);
        sys_rst_n = 0;
        #(30);
        sys_rst_n = 1;
        spi_bits(fr, 20, 72, got);
        #(H);
        spi_cs_n = 1;
        #(400);
        chk("midrst_no_push", 71'(pop_cnt - p0), 71'h0);
        chk("midrst_level", 71'(fifo_level), 71'h0);
        chk("midrst_flags", 71'(err_flags), 71'h0);
        exp_cmd.push_back({7'h0A, 64'h0BAD_BEEF_1357_9BDF});
        spi_frame({1'b0, 7'h0A, 64'h0BAD_BEEF_1357_9BDF}, 72, got);
        wait_drain();
        chk("final_rdaddr_q", 71'(exp_rdaddr.size()), 71'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_cmd_slave.md
# spi_cmd_slave

Parametrised, oversampled SPI mode-0 slave that replaces the fixed 72-bit SPI-clocked receiver in the GPU front end. It samples SCK, MOSI and CS_N in the sys_clk domain, decodes frames of `[R/W̄][ADDR][DATA]`, and queues write commands in an internal FIFO for the register file. Reads are serviced in-frame through a request/response port, with MISO driven during the data phase. Framing errors, FIFO overflow and read underrun are reported through sticky flags.

## Interface
- ADDR_W, 7, register address width.
- DATA_W, 64, register data width. Frame length is `FRAME_W = 1 + ADDR_W + DATA_W`.
- FIFO_DEPTH, 16, write-command FIFO entries; must be a power of 2 and ≥ 2.
- sys_clk  in  1  GPU core clock (clk_core). Must be ≥ 8× the SCK frequency.
- sys_rst_n  in  1  Reset: asynchronous assert, active-low.
- spi_sck, spi_mosi, spi_cs_n  in  1 each  Raw pad inputs, asynchronous to sys_clk.
- spi_miso  out  1  Serial read data. Reset value 0.
- cmd_valid  out  1  FIFO head valid. Reset value 0.
- cmd_ready  in  1  Consumer accepts the FIFO head.
- cmd_addr  out  ADDR_W  Write address at the FIFO head.
- cmd_data  out  DATA_W  Write data at the FIFO head.
- rd_req  out  1  One-cycle read request pulse. Reset value 0.
- rd_addr  out  ADDR_W  Read address; held from rd_req until the end of the frame. Reset value 0.
- rd_valid  in  1  Read data strobe, sampled only while a read response is pending.
- rd_data  in  DATA_W  Read data, captured when rd_valid is high.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  Occupied FIFO entries. Reset value 0.
- err_flags  out  3  Sticky flags: [0] frame abort, [1] FIFO overflow, [2] read underrun. Reset value 0.
- err_clr  in  1  Clears all err_flags. If an error fires in the same cycle, the new error wins.
- err_count  out  8  Error counter; see Configuration. Reset value 0.

## Operation
- Synchronisers:
  - SCK, MOSI and CS_N each pass through 2 flops, plus a third flop for edge detection.
  - `rise` = sync2 & ~sync3; `fall` = ~sync2 & sync3.
  - MOSI uses the same sync depth as SCK, so each bit is sampled on `rise`.
- FSM states and transitions:
  - SYNC: entered after reset. Stays until synced CS_N is high, so a frame already in progress at reset release is never entered mid-frame. Then moves to IDLE.
  - IDLE: shift register and bit counter cleared. Synced CS_N low moves to HDR.
  - HDR: shifts in 1 + ADDR_W bits. On the last header `rise`:
    - R/W̄ = 1: pulse rd_req, latch rd_addr, go to RDATA.
    - R/W̄ = 0: go to WDATA.
  - WDATA: shifts in DATA_W bits. On the last `rise`, push {addr, data} into the FIFO and go to DONE.
  - RDATA:
    - Load the response register when rd_valid arrives.
    - On each `fall`, drive the response MSB-first onto spi_miso.
    - The first `fall` after entering RDATA drives bit DATA_W-1.
    - If no response has been captured by that first `fall`: set underrun, drive 0 for the whole data phase, and ignore any late rd_valid.
    - Count DATA_W `rise`, then go to DONE.
  - DONE: further SCK edges are ignored and spi_miso = 0. Synced CS_N high returns to IDLE.
  - Abort: synced CS_N high while in HDR, WDATA or RDATA discards the frame, sets err_flags[0], and returns to IDLE. No push happens and no rd_req is issued after the abort.
- spi_miso is 0 in every state except RDATA. No tri-state; the pad is handled at top level.
- FIFO (first-word-fall-through):
  - Pop when cmd_valid & cmd_ready.
  - A push while full (with no simultaneous pop) drops the command and sets err_flags[1].
  - A simultaneous push and pop while full is accepted; the level stays at FIFO_DEPTH.
  - Pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- Reads are not ordered against queued writes. The host polls an empty-FIFO status before reading back a just-written register.

## Timing
- Pad to internal edge detect: 3 sys_clk.
- MISO update: 1 sys_clk after `fall` is detected, i.e. ≤ 4 sys_clk after the pad edge.
- FIFO push: on the cycle after the last `rise`. cmd_valid rises 1 cycle after the push when the FIFO was empty.
- rd_req: asserted the cycle after the last header `rise`.
- Read response budget: rd_valid must arrive before the next `fall`, about half an SCK period minus 1 cycle. At 8× oversampling this is ≥ 3 sys_clk.
- Abort: detected 3 sys_clk after CS_N rises at the pad; err_flags[0] is set 1 cycle later.
- Reset assertion: clears the FIFO, FSM, flags and outputs immediately. Any frame in progress is lost.

## Configuration
- SPI_CMD_SLAVE_ERR_COUNT_EN:
  - Defined: err_count is an 8-bit counter that saturates at 255. It increments by 1 in any cycle where at least one err_flags source fires, and is cleared by err_clr.
  - Undefined: err_count is tied to 0 and the counter logic is not synthesised.

## Test plan
- Write frame, addr 0x12, data 0xDEADBEEF_01234567, cmd_ready held high → one cmd_valid beat with exactly those values; fifo_level returns to 0; err_flags = 0.
- Read frame, addr 0x05, rd_valid returned 2 cycles after rd_req with 0xA5A5_0000_FFFF_1234 → MISO bits captured on SCK rise equal that value MSB-first; rd_addr = 0x05.
- Read with no rd_valid → 64 zero bits on MISO; err_flags = 3'b100; err_count = 1 with the macro defined, 0 without.
- 17 write frames with cmd_ready low (depth 16) → fifo_level = 16; err_flags[1] = 1; draining yields the first 16 commands in order.
- CS_N deasserted after 40 bits → no push, no rd_req; err_flags[0] = 1; the next full write frame is accepted normally.
- Reset released while CS_N is low mid-frame, remaining bits clocked → no command is produced; the following clean frame is decoded correctly.
